// File: rtl/dense_rom_reader_pkg.sv
// Shared dimensions and FIFO sizing for the dense-layer weight ROM reader.
package dense_rom_reader_pkg;

    // Model dimensions, kept in step with the project-wide constants.
    localparam int unsigned DATA_N   = 8;
    localparam int unsigned N_LEN    = 12;
    localparam int unsigned HID_DIM  = 128;
    localparam int unsigned CHAR_NUM = 50;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/dense_rom_reader_fifo.sv
// Two-entry FIFO holding {last, data} beats between the ROM and the stream port.
module dense_rom_reader_fifo
    import dense_rom_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 97
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic                  do_push;
    logic                  do_pop;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/dense_rom_reader.sv
// Streams one pass of WORDS weight words from a synchronous-read ROM onto a
// valid/ready port, with a 2-entry skid FIFO absorbing the ROM read latency.
module dense_rom_reader
    import dense_rom_reader_pkg::*;
#(
    parameter int unsigned DWIDTH = DATA_N * N_LEN,
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned WORDS  = HID_DIM / DATA_N * CHAR_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [DWIDTH-1:0] rom_q,
    output logic [DWIDTH-1:0] w_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned       EW        = DWIDTH + 1;
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(WORDS - 1);

    state_t                state_q;
    state_t                state_d;
    logic [AWIDTH-1:0]     addr_cnt_q;
    logic [AWIDTH-1:0]     addr_cnt_d;
    logic [AWIDTH-1:0]     addr_q;
    logic                  in_flight_q;
    logic                  in_flight_last_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  issue_c;
    logic                  pop_c;
    logic                  last_addr_c;
    logic [2:0]            occ_c;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [EW-1:0]         fifo_dout;

    assign pop_c       = w_valid && w_ready;
    assign last_addr_c = (addr_cnt_q == LAST_ADDR);

    // Words buffered after this cycle's pop plus the read still inside the ROM.
    assign occ_c = 3'(fifo_count) + 3'(in_flight_q) - 3'(pop_c);

    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        issue_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    addr_cnt_d = '0;
                end
            end
            FETCH: begin
                if (occ_c < 3'd2) begin
                    issue_c = 1'b1;
                    if (last_addr_c) begin
                        state_d = DRAIN;
                    end else begin
                        addr_cnt_d = addr_cnt_q + AWIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (pop_c && w_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The ROM samples the address at the edge ending the issue cycle; hold it otherwise.
    assign rom_addr = issue_c ? addr_cnt_q : addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            addr_cnt_q       <= '0;
            addr_q           <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_cnt_q       <= addr_cnt_d;
            in_flight_q      <= issue_c;
            in_flight_last_q <= issue_c && last_addr_c;
            busy_q           <= (state_d != IDLE);
            done_q           <= pop_c && w_last;
            if (issue_c) begin
                addr_q <= addr_cnt_q;
            end
        end
    end

    dense_rom_reader_fifo #(
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_flight_q),
        .din   ({in_flight_last_q, rom_q}),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign w_valid = !fifo_empty;
    assign w_last  = fifo_dout[EW-1];
    assign w_data  = fifo_dout[DWIDTH-1:0];
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_dense_rom_reader.sv
// Scoreboard bench for dense_rom_reader with a 1-cycle ROM model holding mem[i]=i.
module tb_dense_rom_reader;

    localparam int unsigned DWIDTH = 96;
    localparam int unsigned AWIDTH = 10;
    localparam int unsigned WORDS  = 800;
    localparam int          BUDGET = 5000;

    logic              clk;
    logic              rst;
    logic              start;
    logic [AWIDTH-1:0] rom_addr;
    logic [DWIDTH-1:0] rom_q;
    logic [DWIDTH-1:0] w_data;
    logic              w_valid;
    logic              w_ready;
    logic              w_last;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    int hold_checks = 0;
    int base_beats = 0;
    int mode = 0;
    bit chk_ost = 0;
    bit ost_viol = 0;

    logic [DWIDTH:0] exp_q [$];

    dense_rom_reader #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .WORDS  (WORDS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .w_data   (w_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_last   (w_last),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk) begin
        rom_q <= DWIDTH'(rom_addr);
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Consumer ready: 0 = always ready, 1 = five-cycle stall at beat 100, 2 = toggling.
    initial begin
        int stall_n;
        stall_n = 0;
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1: begin
                    if ((beat_cnt - base_beats) == 100 && stall_n < 5) begin
                        w_ready = 1'b0;
                        stall_n++;
                    end else begin
                        w_ready = 1'b1;
                    end
                end
                2: w_ready = ~w_ready;
                default: begin
                    w_ready = 1'b1;
                    stall_n = 0;
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks hold/done behaviour.
    initial begin
        logic [DWIDTH:0] e;
        logic [DWIDTH:0] held;
        bit hold_pend;
        bit done_exp;
        hold_pend = 1'b0;
        done_exp  = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
                done_exp  = 1'b0;
            end else begin
                if (done_exp) begin
                    chk("done_pulse_busy", 128'({done, busy}), 128'(2'b10));
                    done_exp = 1'b0;
                end else if (done) begin
                    chk("spurious_done", 128'(done), 128'(0));
                end
                if (done) done_cnt++;
                if (hold_pend) begin
                    chk("hold_valid", 128'(w_valid), 128'(1));
                    chk("hold_data", 128'({w_last, w_data}), 128'(held));
                    hold_checks++;
                end
                if (chk_ost && busy && (int'(rom_addr) > beat_cnt - base_beats + 2)) begin
                    ost_viol = 1'b1;
                end
                if (w_valid && w_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %0h, expected no beat", {w_last, w_data});
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 128'({w_last, w_data}), 128'(e));
                        if (e[DWIDTH]) done_exp = 1'b1;
                    end
                    beat_cnt++;
                end
                hold_pend = w_valid && !w_ready;
                held      = {w_last, w_data};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push_pass();
        for (int i = 0; i < int'(WORDS); i++) begin
            exp_q.push_back({(i == int'(WORDS) - 1), DWIDTH'(i)});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < BUDGET);
        if (t >= BUDGET) chk(name, 128'(t), 128'(0));
    endtask

    task automatic wait_beats(input int n, input string name);
        int t;
        t = 0;
        while ((beat_cnt - base_beats) < n && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        if (t >= BUDGET) chk(name, 128'(beat_cnt - base_beats), 128'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rom_addr"}, 128'(rom_addr), 128'(0));
        chk({tag, "_w_valid"}, 128'(w_valid), 128'(0));
        chk({tag, "_w_last"}, 128'(w_last), 128'(0));
        chk({tag, "_w_data"}, 128'(w_data), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
    endtask

    task automatic end_of_pass(input string tag, input int beats, input int dones, input int d0);
        @(negedge clk);
        chk({tag, "_beats"}, 128'(beat_cnt - base_beats), 128'(beats));
        chk({tag, "_done_cnt"}, 128'(done_cnt - d0), 128'(dones));
        chk({tag, "_queue_left"}, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        int n;
        int d0;
        int h0;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Full-rate pass: latency, 800 gapless beats, done right after beat 799.
        mode = 0; base_beats = beat_cnt; d0 = done_cnt;
        push_pass();
        pulse_start();
        @(negedge clk);
        chk("busy_after_start", 128'(busy), 128'(1));
        chk("valid_edge0", 128'(w_valid), 128'(0));
        @(negedge clk);
        chk("valid_edge1", 128'(w_valid), 128'(0));
        @(negedge clk);
        chk("valid_edge2", 128'(w_valid), 128'(1));
        chk("first_data", 128'(w_data), 128'(0));
        n = 0;
        while (!done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("pass_cycles", 128'(n), 128'(800));
        end_of_pass("full", 800, 1, d0);

        // Five-cycle stall at beat 100.
        mode = 1; base_beats = beat_cnt; d0 = done_cnt; h0 = hold_checks;
        push_pass();
        pulse_start();
        wait_done("stall_timeout");
        end_of_pass("stall", 800, 1, d0);
        chk("stall_holds", 128'(hold_checks - h0), 128'(5));

        // Toggling ready with the outstanding-read bound watched.
        mode = 2; base_beats = beat_cnt; d0 = done_cnt; ost_viol = 1'b0; chk_ost = 1'b1;
        push_pass();
        pulse_start();
        wait_done("toggle_timeout");
        end_of_pass("toggle", 800, 1, d0);
        chk("outstanding", 128'(ost_viol), 128'(0));
        chk_ost = 1'b0;

        // Second start mid-pass is ignored.
        mode = 0; base_beats = beat_cnt; d0 = done_cnt;
        push_pass();
        pulse_start();
        wait_beats(300, "restart_wait");
        pulse_start();
        wait_done("restart_timeout");
        repeat (30) @(negedge clk);
        end_of_pass("restart", 800, 1, d0);
        chk("restart_idle", 128'({busy, w_valid}), 128'(0));

        // Reset at beat 400, then a fresh pass from address 0.
        base_beats = beat_cnt;
        push_pass();
        pulse_start();
        wait_beats(400, "rst_wait");
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        base_beats = beat_cnt; d0 = done_cnt;
        push_pass();
        pulse_start();
        wait_done("postrst_timeout");
        end_of_pass("postrst", 800, 1, d0);

        // Back-to-back passes: start driven in the done cycle.
        base_beats = beat_cnt; d0 = done_cnt;
        push_pass();
        pulse_start();
        wait_done("b2b_first_timeout");
        start = 1'b1;
        push_pass();
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("b2b_second_timeout");
        end_of_pass("b2b", 1600, 2, d0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dense_rom_reader.md
DENSE_ROM_READER -- requirements
Module: dense_rom_reader

Interface
REQ-001 SHALL have parameter DWIDTH, default `DATA_N*`N_LEN (96), the width of one ROM word (DATA_N packed lanes).
REQ-002 SHALL have parameter AWIDTH, default 10, the ROM address width.
REQ-003 SHALL have parameter WORDS, default `HID_DIM/`DATA_N*`CHAR_NUM (800), the number of words per pass.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins a pass.
REQ-007 SHALL have port rom_addr, output, AWIDTH bits: address driven to the synchronous-read weight ROM.
REQ-008 SHALL have port rom_q, input, DWIDTH bits: ROM data, valid one cycle after rom_addr is presented.
REQ-009 SHALL have port w_data, output, DWIDTH bits: stream data.
REQ-010 SHALL have port w_valid, output, 1 bit: stream valid.
REQ-011 SHALL have port w_ready, input, 1 bit: consumer ready.
REQ-012 SHALL have port w_last, output, 1 bit: marks word WORDS-1.
REQ-013 SHALL have port busy, output, 1 bit: a pass is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the last beat is accepted.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, DRAIN; transitions: IDLE->FETCH on start; FETCH->DRAIN after address WORDS-1 is issued; DRAIN->IDLE when the last beat is accepted (w_valid & w_ready & w_last).
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL issue addresses 0..WORDS-1 in ascending order exactly once per pass, with no wrap to 0 within a pass.
REQ-018 SHALL issue an address in a cycle only in FETCH and only if buffer occupancy after this cycle's pop, plus in-flight reads, is below 2.
REQ-019 SHALL capture rom_q into a 2-entry FIFO in the cycle after the corresponding address issue (in-flight flag).
REQ-020 SHALL drive w_valid when the FIFO is non-empty; w_data and w_last are the FIFO head.
REQ-021 SHALL keep w_data and w_last stable while w_valid=1 and w_ready=0.
REQ-022 SHALL handle simultaneous push and pop in one cycle without loss or duplication.
REQ-023 SHALL sustain one beat per cycle with w_ready held high; the first w_valid occurs 2 cycles after the start pulse.
REQ-024 SHALL hold rom_addr at its last issued value when not issuing.
REQ-025 SHALL assert busy from the cycle after start until the cycle done is asserted, inclusive of the FETCH and DRAIN states.
REQ-026 SHALL assert done for exactly one cycle, the cycle after the last beat is accepted, with busy=0 in that cycle.

Reset
REQ-027 SHALL on rst force: state IDLE, rom_addr=0, FIFO empty, in-flight cleared, w_valid=0, w_last=0, w_data=0, busy=0, done=0.
REQ-028 SHALL discard a pass interrupted by reset; after release, the next start begins at address 0.

Structure
REQ-029 SHALL take DATA_N, N_LEN, HID_DIM, and CHAR_NUM from the shared consts.vh; FSM state encodings SHALL be local.
REQ-030 SHALL implement the 2-entry FIFO as one sub-module, dense_rom_reader_fifo, holding {last, data}.

Verification (bench ROM model: 1-cycle synchronous read, mem[i]=i)
REQ-031 SHALL be verified as follows: start, w_ready=1 constant -> w_valid first at start+2, 800 consecutive beats with data 0..799, w_last only on 799, done one cycle later.
REQ-032 SHALL be verified as follows: w_ready=0 for beats 100..104 -> beat 100 held stable, no beat lost or duplicated, total 800 beats.
REQ-033 SHALL be verified as follows: w_ready toggling 1,0 each cycle -> data sequence 0..799 intact, at most 2 reads outstanding plus buffered.
REQ-034 SHALL be verified as follows: second start pulse at beat 300 -> ignored, single pass of 800 beats, one done pulse.
REQ-035 SHALL be verified as follows: rst asserted at beat 400, then a new start -> all outputs return to their reset values immediately, and the new pass begins at data 0.
REQ-036 SHALL be verified as follows: two back-to-back passes (start pulse in the done cycle) -> second pass begins at 0, with 1600 beats in total.
